i2c_bus_monitor: RTL



---
 rtl/i2c_bus_monitor.sv | 97 +++++++++
 1 files changed

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: SCL/SDA synchronizer, optional glitch filter (I2C_GLITCH_FILTER_EN), START/STOP decode, bus-busy FSM
module i2c_bus_monitor #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic rep_start,
    output logic stop_det,
    output logic bus_busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic       scl_d, sda_d;
    logic       start, stop;
    logic [0:0] state;

    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_len_check
        $error("FILTER_LEN must be in 1..15");
    end

    // two-flop resynchronizers, preset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

    logic [3:0] scl_cnt, sda_cnt;

    // a new level is accepted only after persisting FILTER_LEN cycles; any return clears the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_cnt <= '0;
            sda_cnt <= '0;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
        end else begin
            scl_cnt <= (scl_s2 == scl_f || scl_cnt == LAST) ? 4'd0 : scl_cnt + 4'd1;
            sda_cnt <= (sda_s2 == sda_f || sda_cnt == LAST) ? 4'd0 : sda_cnt + 4'd1;
            scl_f   <= (scl_s2 != scl_f && scl_cnt == LAST) ? scl_s2 : scl_f;
            sda_f   <= (sda_s2 != sda_f && sda_cnt == LAST) ? sda_s2 : sda_f;
        end
    end
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    // conditions need SCL high on both samples, so a simultaneous SCL/SDA change yields only the SCL edge
    assign start = scl_f & scl_d & sda_d & ~sda_f;
    assign stop  = scl_f & scl_d & ~sda_d & sda_f;

    // delayed levels, registered event pulses and bus ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            rep_start <= 1'b0;
            stop_det  <= 1'b0;
            state     <= IDLE;
        end else begin
            scl_d     <= scl_f;
            sda_d     <= sda_f;
            scl_rise  <= scl_f & ~scl_d;
            scl_fall  <= ~scl_f & scl_d;
            start_det <= start;
            rep_start <= start & (state == BUSY);
            stop_det  <= stop;
            state     <= stop ? IDLE : start ? BUSY : state;
        end
    end

    assign bus_busy = (state == BUSY);
endmodule
